inst_encoder: RTL and testbench
===============================

# inst_encoder

Streaming RV32I instruction encoder: the inverse of immediate extraction. Accepts one decoded instruction description per valid/ready beat (format, opcode, register fields, functs, full 32-bit immediate) and packs it into a 32-bit instruction word. Each word is written sequentially into instruction memory through a registered write port with backpressure. It sits between the test/boot loader and instruction memory, and range-checks every immediate against its format.

## Interface
- DEPTH_W, 10: instruction-memory word-address width; the program holds at most 2^DEPTH_W words.

- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  one-cycle pulse; begins a program load
- i_base_addr  in  DEPTH_W  first word address, sampled on i_start
- i_valid  in  1  input beat valid
- o_ready  out  1  input beat accepted when i_valid && o_ready
- i_fmt  in  3  0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 I-shift, 7 reserved
- i_opcode  in  7;  i_rd, i_rs1, i_rs2  in  5 each;  i_funct3  in  3;  i_funct7  in  7
- i_imm  in  32  two's-complement immediate / byte offset
- i_last  in  1  marks final beat of program
- o_wr_en  out  1  memory write request
- o_wr_addr  out  DEPTH_W  word address
- o_wr_data  out  32  encoded instruction
- i_wr_ready  in  1  memory accepts write when o_wr_en && i_wr_ready
- o_busy  out  1  state is RUN or DRAIN
- o_done  out  1  level, state is DONE
- o_count  out  DEPTH_W+1  beats accepted this load
- o_err  out  1  sticky error flag
- o_err_code  out  2  first error: 1 imm range, 2 reserved fmt, 3 overflow
- o_err_idx  out  DEPTH_W  0-based beat index of first error

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + i_start -> RUN. Load address := i_base_addr; clear o_count, o_err, o_err_code, o_err_idx.
  - RUN: accepted beat with i_last -> DRAIN.
  - DRAIN: write handshake of the held word -> DONE.
  - i_start in RUN/DRAIN is ignored.
- o_ready = (state==RUN) && (!o_wr_en || i_wr_ready).
- Packing, MSB..LSB:
  - R: funct7, rs2, rs1, funct3, rd, opcode.
  - I: imm[11:0], rs1, funct3, rd, opcode.
  - I-shift: funct7, imm[4:0], rs1, funct3, rd, opcode.
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode.
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode.
  - U: imm[31:12], rd, opcode.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode.
- Range rules; any violation writes 0x00000013 (NOP) instead:
  - I/S: -2048..2047.
  - B: -4096..4094, imm[0]==0.
  - J: -2^20..2^20-2, imm[0]==0.
  - U: imm[11:0]==0.
  - I-shift: imm[31:5]==0.
  - R: imm ignored.
  - Reserved fmt: NOP, code 2.
- Error capture: first error only; later errors do not overwrite. Encoding continues after an error.
- o_err_idx = o_count value at acceptance of the failing beat.
- Address increments by 1 per write handshake, wrapping mod 2^DEPTH_W.
- Overflow: a beat accepted while o_count == 2^DEPTH_W is dropped (not written) and sets code 3. State -> DRAIN, or -> DONE if no word is held. o_count does not increment for a dropped beat.

## Timing
- Reset values: all outputs 0; state IDLE; internal address 0.
- Latency: beat accepted at edge N -> o_wr_en=1 with o_wr_addr/o_wr_data valid after edge N.
- o_wr_* stay stable while o_wr_en && !i_wr_ready.
- Throughput: 1 word/cycle with i_wr_ready held high; accept and handshake may occur in the same cycle.
- o_count increments at the acceptance edge.
- o_done rises the cycle after the final write handshake.
- Async reset mid-load: immediate return to reset values; the pending word is discarded.

## Test plan
- Reset, i_start base 0x010, one I beat (opcode 0x13, rd 1, funct3 0, imm -1, last) -> write 0xFFF00093 at 0x010, o_done next cycle, o_count 1.
- B beat (opcode 0x63, rs1 1, rs2 2, funct3 0, imm -4), then J beat (opcode 0x6F, rd 1, imm 2048, last) -> writes 0xFE208EE3, 0x001000EF at consecutive addresses.
- 4 beats; beat 2 is I with imm 2048, beat 3 has fmt 7 -> beat 2 writes 0x00000013, o_err 1, code 1, idx 2 (fmt-7 beat does not overwrite); other beats encode normally.
- 3 beats with i_wr_ready low for 2 cycles after the first beat is accepted -> o_wr_data held, o_ready 0, no beat lost, addresses base..base+2.
- DEPTH_W=4, base 0xE, 3 beats -> addresses 0xE, 0xF, 0x0.
- DEPTH_W=4, 17 beats -> 16 writes, 17th dropped, code 3, idx 0, o_count 16, state DONE.

Source files
------------

// File: rtl/inst_encoder.sv
// Streaming RV32I encoder: packs decoded instruction fields into 32-bit words and
// writes them sequentially to instruction memory, replacing out-of-range encodings with NOP.
module inst_encoder #(
  parameter int DEPTH_W = 10
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [DEPTH_W-1:0] i_base_addr,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [2:0]         i_fmt,
  input  logic [6:0]         i_opcode,
  input  logic [4:0]         i_rd,
  input  logic [4:0]         i_rs1,
  input  logic [4:0]         i_rs2,
  input  logic [2:0]         i_funct3,
  input  logic [6:0]         i_funct7,
  input  logic [31:0]        i_imm,
  input  logic               i_last,
  output logic               o_wr_en,
  output logic [DEPTH_W-1:0] o_wr_addr,
  output logic [31:0]        o_wr_data,
  input  logic               i_wr_ready,
  output logic               o_busy,
  output logic               o_done,
  output logic [DEPTH_W:0]   o_count,
  output logic               o_err,
  output logic [1:0]         o_err_code,
  output logic [DEPTH_W-1:0] o_err_idx
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             r_state;
  logic               r_wrEn;
  logic [DEPTH_W-1:0] r_addr;
  logic [31:0]        r_wrData;
  logic               r_busy;
  logic               r_done;
  logic [DEPTH_W:0]   r_count;
  logic               r_err;
  logic [1:0]         r_errCode;
  logic [DEPTH_W-1:0] r_errIdx;

  logic        w_wrFire;
  logic        w_ready;
  logic        w_accept;
  logic        w_full;
  logic        w_fitsI;
  logic        w_fitsB;
  logic        w_fitsJ;
  logic        w_immBad;
  logic        w_fmtBad;
  logic [31:0] w_word;
  logic [31:0] w_wrWord;

  assign w_wrFire = r_wrEn && i_wr_ready;
  assign w_ready  = (r_state == RUN) && (!r_wrEn || i_wr_ready);
  assign w_accept = i_valid && w_ready;
  // o_count never exceeds 2^DEPTH_W, so its MSB alone flags a full program.
  assign w_full   = r_count[DEPTH_W];

  // Signed range checks: the bits above the field's sign bit must all equal it.
  assign w_fitsI = (&i_imm[31:11]) || !(|i_imm[31:11]);
  assign w_fitsB = (&i_imm[31:12]) || !(|i_imm[31:12]);
  assign w_fitsJ = (&i_imm[31:20]) || !(|i_imm[31:20]);

  always_comb begin
    w_word   = NOP;
    w_immBad = 1'b0;
    w_fmtBad = 1'b0;
    case (i_fmt)
      3'd0: w_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      3'd1: begin
        w_immBad = !w_fitsI;
        w_word   = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
      end
      3'd2: begin
        w_immBad = !w_fitsI;
        w_word   = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
      end
      3'd3: begin
        w_immBad = !w_fitsB || i_imm[0];
        w_word   = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                    i_imm[4:1], i_imm[11], i_opcode};
      end
      3'd4: begin
        w_immBad = |i_imm[11:0];
        w_word   = {i_imm[31:12], i_rd, i_opcode};
      end
      3'd5: begin
        w_immBad = !w_fitsJ || i_imm[0];
        w_word   = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
      end
      3'd6: begin
        w_immBad = |i_imm[31:5];
        w_word   = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, i_opcode};
      end
      default: w_fmtBad = 1'b1;
    endcase
  end

  assign w_wrWord = (w_immBad || w_fmtBad) ? NOP : w_word;

  // r_addr tracks the write port address; it advances on each handshake, so a beat
  // accepted in the same cycle as a handshake lands on the following address.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_wrEn    <= 1'b0;
      r_addr    <= '0;
      r_wrData  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_count   <= '0;
      r_err     <= 1'b0;
      r_errCode <= 2'd0;
      r_errIdx  <= '0;
    end else begin
      if (w_wrFire) begin
        r_wrEn <= 1'b0;
        r_addr <= r_addr + 1'b1;
      end
      case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_state   <= RUN;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_addr    <= i_base_addr;
            r_count   <= '0;
            r_err     <= 1'b0;
            r_errCode <= 2'd0;
            r_errIdx  <= '0;
          end
        end
        RUN: begin
          if (w_accept) begin
            if (w_full) begin
              if (!r_err) begin
                r_err     <= 1'b1;
                r_errCode <= 2'd3;
                r_errIdx  <= r_count[DEPTH_W-1:0];
              end
              if (r_wrEn && !i_wr_ready) begin
                r_state <= DRAIN;
              end else begin
                r_state <= DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_wrEn   <= 1'b1;
              r_wrData <= w_wrWord;
              r_count  <= r_count + 1'b1;
              if (!r_err && (w_immBad || w_fmtBad)) begin
                r_err     <= 1'b1;
                r_errCode <= w_fmtBad ? 2'd2 : 2'd1;
                r_errIdx  <= r_count[DEPTH_W-1:0];
              end
              if (i_last) r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_wrFire) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ready    = w_ready;
  assign o_wr_en    = r_wrEn;
  assign o_wr_addr  = r_addr;
  assign o_wr_data  = r_wrData;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_count    = r_count;
  assign o_err      = r_err;
  assign o_err_code = r_errCode;
  assign o_err_idx  = r_errIdx;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: one 10-bit and one 4-bit address instance share
// the stimulus bus; only the instance that received i_start accepts beats.
module tb_inst_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN;
  logic        startA, startB;
  logic [9:0]  baseA;
  logic [3:0]  baseB;
  logic        valid;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm;
  logic        last;
  logic        wrReady;

  logic        readyA, wrEnA, busyA, doneA, errA;
  logic [9:0]  wrAddrA, errIdxA;
  logic [31:0] wrDataA;
  logic [10:0] countA;
  logic [1:0]  errCodeA;

  logic        readyB, wrEnB, busyB, doneB, errB;
  logic [3:0]  wrAddrB, errIdxB;
  logic [31:0] wrDataB;
  logic [4:0]  countB;
  logic [1:0]  errCodeB;

  int          checks = 0;
  int          failures = 0;
  logic [41:0] expQ[$];
  logic        sel = 1'b0;
  logic [9:0]  expAddr = '0;
  logic [9:0]  addrMask = 10'h3FF;

  inst_encoder #(.DEPTH_W(10)) dutA (
    .i_clk(clk), .i_rst_n(rstN), .i_start(startA), .i_base_addr(baseA),
    .i_valid(valid), .o_ready(readyA), .i_fmt(fmt), .i_opcode(opcode),
    .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2), .i_funct3(f3), .i_funct7(f7),
    .i_imm(imm), .i_last(last), .o_wr_en(wrEnA), .o_wr_addr(wrAddrA),
    .o_wr_data(wrDataA), .i_wr_ready(wrReady), .o_busy(busyA), .o_done(doneA),
    .o_count(countA), .o_err(errA), .o_err_code(errCodeA), .o_err_idx(errIdxA)
  );

  inst_encoder #(.DEPTH_W(4)) dutB (
    .i_clk(clk), .i_rst_n(rstN), .i_start(startB), .i_base_addr(baseB),
    .i_valid(valid), .o_ready(readyB), .i_fmt(fmt), .i_opcode(opcode),
    .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2), .i_funct3(f3), .i_funct7(f7),
    .i_imm(imm), .i_last(last), .o_wr_en(wrEnB), .o_wr_addr(wrAddrB),
    .o_wr_data(wrDataB), .i_wr_ready(wrReady), .o_busy(busyB), .o_done(doneB),
    .o_count(countB), .o_err(errB), .o_err_code(errCodeB), .o_err_idx(errIdxB)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  function automatic logic curReady();
    return sel ? readyB : readyA;
  endfunction

  function automatic logic curDone();
    return sel ? doneB : doneA;
  endfunction

  // Monitors: every write handshake pops the next expected {addr, data}.
  always @(negedge clk) begin : monA
    logic [41:0] e;
    if (rstN && wrEnA && wrReady) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_write_a", 32'(expQ.size()), 32'd1);
      end else begin
        e = expQ.pop_front();
        checkOutput("wr_addr_a", 32'(wrAddrA), 32'(e[41:32]));
        checkOutput("wr_data_a", wrDataA, e[31:0]);
      end
    end
  end

  always @(negedge clk) begin : monB
    logic [41:0] e;
    if (rstN && wrEnB && wrReady) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_write_b", 32'(expQ.size()), 32'd1);
      end else begin
        e = expQ.pop_front();
        checkOutput("wr_addr_b", 32'(wrAddrB), 32'(e[41:32]));
        checkOutput("wr_data_b", wrDataB, e[31:0]);
      end
    end
  end

  task automatic startLoad(input logic s, input logic [9:0] b);
    sel      = s;
    addrMask = s ? 10'h00F : 10'h3FF;
    expAddr  = b & addrMask;
    baseA    = b;
    baseB    = b[3:0];
    @(posedge clk); #1;
    if (s) startB = 1'b1;
    else   startA = 1'b1;
    @(posedge clk); #1;
    startA = 1'b0;
    startB = 1'b0;
  endtask

  task automatic applyStimulus(input logic [2:0] f, input logic [6:0] op,
                               input logic [4:0] d, input logic [4:0] s1,
                               input logic [4:0] s2, input logic [2:0] fn3,
                               input logic [6:0] fn7, input logic [31:0] im,
                               input logic lst, input logic expWrite,
                               input logic [31:0] expData);
    bit got = 0;
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
    f3 = fn3; f7 = fn7; imm = im; last = lst; valid = 1'b1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (curReady()) got = 1;
    end
    if (got) begin
      if (expWrite) begin
        expQ.push_back({expAddr, expData});
        expAddr = (expAddr + 10'd1) & addrMask;
      end
      @(posedge clk); #1;
    end else begin
      checkOutput("ready_timeout", 32'(curReady()), 32'd1);
    end
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic waitDone(input string name);
    bit got = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (curDone()) got = 1;
    end
    checkOutput(name, 32'(curDone()), 32'd1);
    checkOutput({name, "_queue_empty"}, 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rstN = 1'b0; startA = 1'b0; startB = 1'b0; baseA = '0; baseB = '0;
    valid = 1'b0; fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
    f3 = '0; f7 = '0; imm = '0; last = 1'b0; wrReady = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 32'(readyA), 0);
    checkOutput("rst_wr_en", 32'(wrEnA), 0);
    checkOutput("rst_wr_addr", 32'(wrAddrA), 0);
    checkOutput("rst_wr_data", wrDataA, 0);
    checkOutput("rst_busy_done", {30'b0, busyA, doneA}, 0);
    checkOutput("rst_count", 32'(countA), 0);
    checkOutput("rst_err", {27'b0, errA, errCodeA, 2'b0}, 0);
    checkOutput("rst_err_idx", 32'(errIdxA), 0);
    @(posedge clk); #1;
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("idle_ready", 32'(readyA), 0);

    // Single I beat, addi x1, x0, -1.
    startLoad(1'b0, 10'h010);
    applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFFF0_0093);
    @(negedge clk);
    checkOutput("t1_busy_drain", 32'(busyA), 1);
    checkOutput("t1_done_early", 32'(doneA), 0);
    @(negedge clk);
    checkOutput("t1_done", 32'(doneA), 1);
    checkOutput("t1_busy_after", 32'(busyA), 0);
    checkOutput("t1_count", 32'(countA), 1);
    checkOutput("t1_err", 32'(errA), 0);

    // B then J.
    startLoad(1'b0, 10'h020);
    applyStimulus(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'hFE20_8EE3);
    applyStimulus(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1, 1'b1, 32'h0010_00EF);
    waitDone("t2_done");
    checkOutput("t2_count", 32'(countA), 2);
    checkOutput("t2_err", 32'(errA), 0);

    // Immediate range edges, with 10-bit address wrap.
    startLoad(1'b0, 10'h3FE);
    applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047, 1'b0, 1'b1, 32'h7FF0_0093);
    applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 1'b0, 1'b1, 32'h8000_0093);
    applyStimulus(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094, 1'b0, 1'b1, 32'h7E00_0FE3);
    applyStimulus(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F000, 1'b0, 1'b1, 32'h8000_0063);
    applyStimulus(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 1'b0, 1'b1, 32'h0000_0013);
    applyStimulus(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, 1'b1, 1'b1, 32'h0000_0013);
    waitDone("tb_done");
    checkOutput("tb_count", 32'(countA), 6);
    checkOutput("tb_err", 32'(errA), 1);
    checkOutput("tb_err_code", 32'(errCodeA), 1);
    checkOutput("tb_err_idx", 32'(errIdxA), 4);

    // First error sticks; the later reserved-format beat does not overwrite it.
    startLoad(1'b0, 10'h040);
    applyStimulus(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0020_81B3);
    applyStimulus(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0, 1'b1, 32'h0020_A423);
    applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 1'b1, 32'h0000_0013);
    applyStimulus(3'd7, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 1'b1, 1'b1, 32'h0000_0013);
    waitDone("t3_done");
    checkOutput("t3_count", 32'(countA), 4);
    checkOutput("t3_err", 32'(errA), 1);
    checkOutput("t3_err_code", 32'(errCodeA), 1);
    checkOutput("t3_err_idx", 32'(errIdxA), 2);

    // Write backpressure for two cycles after the first acceptance.
    startLoad(1'b0, 10'h100);
    applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0, 1'b1, 32'h0010_0093);
    wrReady = 1'b0;
    fork
      applyStimulus(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b0, 1'b1, 32'h0020_0113);
      begin
        for (int c = 0; c < 2; c++) begin
          @(negedge clk);
          checkOutput("t4_stall_ready", 32'(readyA), 0);
          checkOutput("t4_stall_wr_en", 32'(wrEnA), 1);
          checkOutput("t4_stall_data", wrDataA, 32'h0010_0093);
          checkOutput("t4_stall_addr", 32'(wrAddrA), 32'h100);
          @(posedge clk); #1;
        end
        wrReady = 1'b1;
      end
    join
    applyStimulus(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 1'b1, 32'h0020_81B3);
    waitDone("t4_done");
    checkOutput("t4_count", 32'(countA), 3);

    // 4-bit instance: U, I-shift, J across the address wrap.
    startLoad(1'b1, 10'h00E);
    applyStimulus(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b0, 1'b1, 32'h1234_52B7);
    applyStimulus(3'd6, 7'h13, 5'd6, 5'd7, 5'd0, 3'd5, 7'h20, 32'd3, 1'b0, 1'b1, 32'h4033_D313);
    applyStimulus(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFF8, 1'b1, 1'b1, 32'hFF9F_F06F);
    waitDone("t5_done");
    checkOutput("t5_count", 32'(countB), 3);
    checkOutput("t5_err", 32'(errB), 0);

    // Overflow: 17th beat dropped.
    startLoad(1'b1, 10'h003);
    for (int k = 0; k < 16; k++) begin
      applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(k), 1'b0, 1'b1,
                    (32'(k) << 20) | 32'h93);
    end
    applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd99, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t6_done", 32'(doneB), 1);
    checkOutput("t6_count", 32'(countB), 16);
    checkOutput("t6_err", 32'(errB), 1);
    checkOutput("t6_err_code", 32'(errCodeB), 3);
    checkOutput("t6_err_idx", 32'(errIdxB), 0);
    checkOutput("t6_queue_empty", 32'(expQ.size()), 0);

    // Asynchronous reset with a word pending.
    startLoad(1'b0, 10'h200);
    wrReady = 1'b0;
    applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 1'b0, 32'h0);
    #2;
    checkOutput("t7_pending", 32'(wrEnA), 1);
    rstN = 1'b0;
    #1;
    checkOutput("t7_rst_wr_en", 32'(wrEnA), 0);
    checkOutput("t7_rst_busy", 32'(busyA), 0);
    checkOutput("t7_rst_count", 32'(countA), 0);
    checkOutput("t7_rst_addr", 32'(wrAddrA), 0);
    @(posedge clk); #1;
    rstN = 1'b1;
    wrReady = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("t7_idle_wr_en", 32'(wrEnA), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
